// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream to Wishbone program loader.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      RECOVER = 2'd2
   } state_e;

   localparam int FRAME_BYTES     = 8;
   localparam int BYTE_CNT_W      = $clog2(FRAME_BYTES);
   localparam int DEF_WB_WIDTH    = 32;
   localparam int DEF_TIMEOUT     = 15;
   localparam int DEF_FRAME_CNT_W = 16;

endpackage

// File: rtl/loader_frame_asm.sv
// Frame assembler: shifts accepted bytes MSB-first and counts them. The holding
// register keeps the first seven bytes; the eighth is taken straight from the input.
module loader_frame_asm
   import prog_loader_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     clr_i,
   input  logic [7:0]               data_i,
   input  logic                     valid_i,
   input  logic                     sync_i,
   output logic [BYTE_CNT_W-1:0]    cnt_o,
   output logic                     done_o,
   output logic [8*FRAME_BYTES-1:0] frame_o
);

   localparam int HOLD_W = 8 * (FRAME_BYTES - 1);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_BYTES - 1);

   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
   logic                  take;

   assign take = en_i && valid_i;

   always_comb begin
      hold_d = hold_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && sync_i) begin
         // Resync drops the partial frame; a byte in the same cycle starts the new one.
         cnt_d  = take ? BYTE_CNT_W'(1) : '0;
         hold_d = take ? {{(HOLD_W-8){1'b0}}, data_i} : '0;
      end else if (take) begin
         cnt_d  = cnt_q + 1'b1;
         hold_d = {hold_q[HOLD_W-9:0], data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q <= '0;
         cnt_q  <= '0;
      end else begin
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign done_o  = take && !sync_i && (cnt_q == LAST_BYTE);
   assign frame_o = {hold_q, data_i};

endmodule

// File: rtl/prog_loader.sv
// Collects 8-byte address/data frames from a byte stream and issues one
// Wishbone write per frame, with ack timeout, sticky error and a frame counter.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int WB_WIDTH    = DEF_WB_WIDTH,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sync,
   output logic                   wbm_cyc_o,
   output logic                   wbm_stb_o,
   output logic                   wbm_we_o,
   output logic [WB_WIDTH-1:0]    wbm_adr_o,
   output logic [WB_WIDTH-1:0]    wbm_dat_o,
   input  logic                   wbm_ack_i,
   output logic                   busy_o,
   output logic                   err_o,
   input  logic                   err_clr_i,
   output logic [FRAME_CNT_W-1:0] frames_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e                   state_q, state_d;
   logic [WAIT_W-1:0]        wait_q, wait_d;
   logic [WB_WIDTH-1:0]      adr_q, adr_d, dat_q, dat_d;
   logic                     err_q, err_d;
   logic [FRAME_CNT_W-1:0]   frames_q, frames_d;
   logic                     collecting, asm_clr, frame_done;
   logic [BYTE_CNT_W-1:0]    byte_cnt;
   logic [8*FRAME_BYTES-1:0] frame;

   assign collecting = (state_q == COLLECT);

   loader_frame_asm u_frame_asm (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_i),
      .en_i    (collecting),
      .clr_i   (asm_clr),
      .data_i  (in_data),
      .valid_i (in_valid),
      .sync_i  (in_sync),
      .cnt_o   (byte_cnt),
      .done_o  (frame_done),
      .frame_o (frame)
   );

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      err_d    = err_q;
      frames_d = frames_q;
      asm_clr  = 1'b0;
      if (err_clr_i) err_d = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (frame_done) begin
               adr_d   = WB_WIDTH'(frame[63:32]);
               dat_d   = WB_WIDTH'(frame[31:0]);
               wait_d  = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // Ack is checked first so an ack on the last allowed cycle still completes.
            if (wbm_ack_i) begin
               frames_d = frames_q + 1'b1;
               asm_clr  = 1'b1;
               state_d  = COLLECT;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = RECOVER;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         RECOVER: begin
            asm_clr = 1'b1;
            state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q  <= COLLECT;
         wait_q   <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         err_q    <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         err_q    <= err_d;
         frames_q <= frames_d;
      end
   end

   assign in_ready  = collecting;
   assign wbm_cyc_o = (state_q == WRITE);
   assign wbm_stb_o = (state_q == WRITE);
   assign wbm_we_o  = (state_q == WRITE);
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign busy_o    = (byte_cnt != '0) || !collecting;
   assign err_o     = err_q;
   assign frames_o  = frames_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: queue-based reference model compared every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_prog_loader;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0, in_sync = 1'b0, err_clr = 1'b0;
   logic        ack_force = 1'b0, resp_ack = 1'b0;
   logic        in_ready, cyc, stb, we, ack, busy, err;
   logic [31:0] adr, dat;
   logic [15:0] frames;

   int checks = 0, errors = 0;
   bit chk_en = 1'b0, ack_en = 1'b1;
   int ack_delay = 1, resp_wait = 0;
   int run_len = 0, last_run = 0;
   logic [63:0] wlog[$];

   // Reference model state
   bit          m_write = 0, m_recover = 0, m_err = 0, m_timeout = 0;
   int          m_age = 0;
   logic [31:0] m_adr = '0, m_dat = '0;
   logic [15:0] m_frames = '0;
   logic [7:0]  part[$];

   assign ack = resp_ack | ack_force;
   always #5 clk = ~clk;

   prog_loader dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sync   (in_sync),
      .wbm_cyc_o (cyc),
      .wbm_stb_o (stb),
      .wbm_we_o  (we),
      .wbm_adr_o (adr),
      .wbm_dat_o (dat),
      .wbm_ack_i (ack),
      .busy_o    (busy),
      .err_o     (err),
      .err_clr_i (err_clr),
      .frames_o  (frames)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave responder: ack on the (ack_delay+1)-th strobe cycle.
   always @(posedge clk) begin
      #1;
      if (cyc && ack_en) begin
         resp_ack = (resp_wait == ack_delay);
         resp_wait++;
      end else begin
         resp_ack = 1'b0;
         resp_wait = 0;
      end
   end

   // Reference model: frame bytes in a queue, write age in plain cycles.
   always @(posedge clk) begin
      m_timeout = 0;
      if (!rst_n) begin
         m_write = 0; m_recover = 0; m_err = 0; m_age = 0;
         m_adr = '0; m_dat = '0; m_frames = '0;
         part.delete();
      end else begin
         if (m_write) begin
            if (ack) begin
               m_write = 0;
               m_frames = m_frames + 16'd1;
            end else if (m_age + 1 == TIMEOUT) begin
               m_write = 0; m_recover = 1; m_timeout = 1;
            end else begin
               m_age++;
            end
         end else if (m_recover) begin
            m_recover = 0;
         end else begin
            if (in_sync) part.delete();
            if (in_valid) begin
               part.push_back(in_data);
               if (part.size() == 8) begin
                  m_adr = {part[0], part[1], part[2], part[3]};
                  m_dat = {part[4], part[5], part[6], part[7]};
                  m_write = 1; m_age = 0;
                  part.delete();
               end
            end
         end
         if (m_timeout) m_err = 1;
         else if (err_clr) m_err = 0;
      end
   end

   always @(posedge clk) begin
      if (rst_n && cyc && stb && ack) begin
         wlog.push_back({adr, dat});
         $display("WRITE adr=%08h dat=%08h", adr, dat);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(!m_write && !m_recover));
         chk("cyc", 64'(cyc), 64'(m_write));
         chk("stb", 64'(stb), 64'(m_write));
         chk("we", 64'(we), 64'(m_write));
         chk("adr", 64'(adr), 64'(m_adr));
         chk("dat", 64'(dat), 64'(m_dat));
         chk("busy", 64'(busy), 64'(part.size() != 0 || m_write || m_recover));
         chk("err", 64'(err), 64'(m_err));
         chk("frames", 64'(frames), 64'(m_frames));
      end
      if (stb) run_len++;
      else if (run_len != 0) begin
         last_run = run_len;
         $display("STB run ended after %0d cycles", run_len);
         run_len = 0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; err_clr = 1'b0; ack_force = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wlog.delete();
   endtask

   // Must be called just after a rising edge; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk("in_ready_timeout", 64'(in_ready), 64'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input bit last);
      logic [63:0] f;
      f = {a, d};
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
      if (last) in_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      int k = 0;
      while (wlog.size() < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("write_count", 64'(wlog.size()), 64'(n));
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_cyc_fall();
      int k = 0;
      while (!cyc && k < 50) begin @(negedge clk); k++; end
      while (cyc && k < 100) begin @(negedge clk); k++; end
      chk("cyc_fall", 64'(cyc), 64'(0));
   endtask

   initial begin
      logic [63:0] seq;

      do_reset();
      chk_en = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_cyc", 64'(cyc), 64'(0));
      chk("rst_adr", 64'(adr), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_frames", 64'(frames), 64'(0));

      // Single frame, ack one cycle after strobe
      ack_en = 1'b1; ack_delay = 1;
      send_frame(32'h40000000, 32'h00000001, 1'b1);
      wait_writes(1);
      chk("w1", wlog[0], 64'h40000000_00000001);
      chk("w1_frames", 64'(frames), 64'(1));
      chk("w1_err", 64'(err), 64'(0));
      chk("w1_run", 64'(last_run), 64'(2));

      // Back-to-back frames, ack delayed 3 cycles
      do_reset();
      ack_delay = 3;
      send_frame(32'h00000002, 32'hA0000000, 1'b0);
      send_frame(32'h00000009, 32'hA0000001, 1'b1);
      wait_writes(2);
      chk("b2b_0", wlog[0], 64'h00000002_A0000000);
      chk("b2b_1", wlog[1], 64'h00000009_A0000001);
      chk("b2b_frames", 64'(frames), 64'(2));
      chk("b2b_run", 64'(last_run), 64'(4));

      // Timeout with no ack, then clear the error
      do_reset();
      ack_en = 1'b0;
      send_frame(32'h12345678, 32'h9ABCDEF0, 1'b1);
      wait_cyc_fall();
      @(negedge clk);
      chk("to_run", 64'(last_run), 64'(TIMEOUT));
      chk("to_err", 64'(err), 64'(1));
      chk("to_frames", 64'(frames), 64'(0));
      chk("to_writes", 64'(wlog.size()), 64'(0));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_err_clr", 64'(err), 64'(0));

      // Ack on the last allowed cycle wins over timeout
      do_reset();
      ack_en = 1'b1; ack_delay = TIMEOUT - 1;
      send_frame(32'hCAFE0000, 32'h0000BEEF, 1'b1);
      wait_writes(1);
      chk("edge_w", wlog[0], 64'hCAFE0000_0000BEEF);
      chk("edge_err", 64'(err), 64'(0));
      chk("edge_frames", 64'(frames), 64'(1));
      chk("edge_run", 64'(last_run), 64'(TIMEOUT));

      // Timeout while err_clr held: set wins, clear takes effect next cycle
      ack_en = 1'b0; err_clr = 1'b1;
      send_frame(32'h00000010, 32'h00000020, 1'b1);
      wait_cyc_fall();
      chk("setwins_err", 64'(err), 64'(1));
      @(negedge clk);
      chk("setwins_clr", 64'(err), 64'(0));
      err_clr = 1'b0;

      // Partial bytes discarded by in_sync; stray acks ignored while collecting
      do_reset();
      ack_en = 1'b1; ack_delay = 1;
      @(posedge clk); #1;
      ack_force = 1'b1;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      ack_force = 1'b0; in_valid = 1'b0; in_sync = 1'b1;
      @(posedge clk); #1;
      in_sync = 1'b0;
      send_frame(32'h40000000, 32'h00000000, 1'b1);
      wait_writes(1);
      chk("sync_w", wlog[0], 64'h40000000_00000000);
      chk("sync_frames", 64'(frames), 64'(1));

      // in_sync together with a byte makes that byte the first of a new frame
      @(posedge clk); #1;
      send_byte(8'hAA); send_byte(8'hBB);
      in_sync = 1'b1;
      send_byte(8'h00);
      in_sync = 1'b0;
      seq = 64'h00_00_00_07_DE_AD_BE_EF;
      for (int i = 1; i < 8; i++) send_byte(seq[63-8*i -: 8]);
      in_valid = 1'b0;
      wait_writes(2);
      chk("sync_valid_w", wlog[1], 64'h00000007_DEADBEEF);

      // Reset in the middle of a write, then a clean frame
      do_reset();
      ack_en = 1'b0;
      send_frame(32'hAAAA0000, 32'h00005555, 1'b1);
      repeat (3) @(negedge clk);
      chk("mid_cyc_before", 64'(cyc), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_cyc_after", 64'(cyc), 64'(0));
      chk("mid_frames", 64'(frames), 64'(0));
      rst_n = 1'b1;
      wlog.delete();
      ack_en = 1'b1; ack_delay = 1;
      send_frame(32'h00000001, 32'h12345678, 1'b1);
      wait_writes(1);
      chk("mid_w", wlog[0], 64'h00000001_12345678);
      chk("mid_frames_after", 64'(frames), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
